fifo8x9_ctrl: RTL and testbench
===============================

# fifo8x9_ctrl

Sequencing controller for the 8-deep, 9-bit register-file FIFO datapath. It turns requester-side write/read requests into the datapath strobes `wren`, `WrInc`, `rden`, `RdInc`, `WrPtrClr` and `RdPtrClr`. It also tracks occupancy, so full/empty protection lives here rather than in the datapath. It sits between the producer/consumer logic and the FIFO datapath instance, one controller per FIFO.

## Interface
- `DEPTH`, 8, number of FIFO entries; must match the datapath depth.
- `CNT_W`, 4, occupancy counter width; must hold 0..DEPTH.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_req`  in  1  producer requests a write this cycle.
- `rd_req`  in  1  consumer requests a read this cycle.
- `flush`  in  1  discard contents and clear both pointers.
- `wr_ready`  out  1  a write would be accepted (READY and not full).
- `rd_ready`  out  1  a read would be accepted (READY and not empty).
- `wren`  out  1  datapath write enable.
- `WrInc`  out  1  datapath write-pointer increment.
- `rden`  out  1  datapath read (output) enable.
- `RdInc`  out  1  datapath read-pointer increment.
- `WrPtrClr`  out  1  datapath write-pointer clear.
- `RdPtrClr`  out  1  datapath read-pointer clear.
- `rd_valid`  out  1  datapath `DataOut` holds accepted read data.
- `count`  out  CNT_W  current occupancy, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `err_ovf`  out  1  sticky overflow flag (see Configuration).
- `err_udf`  out  1  sticky underflow flag (see Configuration).

## Operation
- The FSM has three states: INIT, READY and FLUSH.
  - Reset forces INIT.
  - INIT → READY unconditionally after one cycle.
  - READY → FLUSH when `flush`=1.
  - FLUSH → READY unconditionally after one cycle.
- INIT and FLUSH assert `WrPtrClr`=`RdPtrClr`=1, force `wr_ready`=`rd_ready`=0, ignore requests and load `count` with 0.
- Write and read acceptance in READY with `flush`=0:
  - `wr_acc` = `wr_req` & (!`full` | `rd_req`).
  - `rd_acc` = `rd_req` & !`empty`.
- `flush`=1 in READY has priority: the same cycle's requests are dropped and raise no error.
- Strobes are combinational decodes of the registered state and the inputs:
  - `wren`=`WrInc`=`wr_acc`.
  - `rden`=`RdInc`=`rd_acc`.
- Occupancy update:
  - `wr_acc` only: `count`+1.
  - `rd_acc` only: `count`−1.
  - Both or neither: `count` unchanged.
  - `count` never leaves 0..DEPTH.
- Full with both requests: both are accepted and `count` stays at DEPTH. The datapath reads the oldest entry while writing the freed slot.
- Empty with both requests: only the write is accepted. There is no bypass. `count` becomes 1.
- Pointer wrap-around is handled in the datapath. The controller only guarantees that the number of increments never exceeds the number of entries.
- `rd_valid` is `rd_acc` registered by one cycle, so it tracks the registered `DataOut`.

## Timing
- Reset values: state INIT, `count`=0, `empty`=1, `full`=0, `rd_valid`=0, `err_ovf`=`err_udf`=0.
- Reset values of the decoded outputs: all strobes and readies are 0 while `rst`=1.
- First cycle after `rst` falls: INIT, with `WrPtrClr`=`RdPtrClr`=1 and both readies 0.
- Second cycle after `rst` falls: READY, and requests can be accepted.
- Write latency: data on `DataIn` is captured on the same edge where `wren`=1.
- Read latency: `rd_acc` in cycle N gives data and `rd_valid`=1 in cycle N+1.
- `full`, `empty` and `count` update on the edge following the accepting cycle.
- Flush sampled in cycle N: the FLUSH state runs in cycle N+1 and READY returns in cycle N+2 with `count`=0.
- A `rd_valid` already scheduled from cycle N still asserts in cycle N+1.
- Reset mid-operation: takes effect on the next edge, discards any pending `rd_valid`, then re-runs INIT.

## Configuration
- Macro: `FIFO8X9_CTRL_ERR_EN`.
- Defined:
  - `err_ovf` sets on READY & `wr_req` & `full` & !`rd_req` & !`flush`.
  - `err_udf` sets on READY & `rd_req` & `empty` & !`flush`.
  - Both flags are sticky until `rst` or a flush is accepted; FLUSH clears them.
- Undefined: `err_ovf`=`err_udf`=0 constant, and no error logic is synthesized.
- Request acceptance is identical in both builds.

## Test plan
- Release `rst` → one cycle of INIT with `WrPtrClr`=`RdPtrClr`=1, then READY with `empty`=1 and `count`=0.
- 8 consecutive writes of 0x101..0x108 → `count`=8 and `full`=1; a 9th lone write gets `wren`=0, `count` stays 8 and `err_ovf`=1 (ERR_EN).
- 8 reads after the fill → 0x101..0x108 in order, each with `rd_valid` one cycle after `rden`; then `empty`=1 and `count`=0.
- At `count`=8, `wr_req`=`rd_req`=1 for 3 cycles → `wren`=`rden`=1 every cycle, `count`=8 throughout, and FIFO order preserved.
- At `count`=5, pulse `flush` together with `wr_req` → no `wren`, FLUSH clears both pointers, then READY with `count`=0 and error flags cleared.
- When empty, `rd_req` alone → `rden`=0, `err_udf`=1 (ERR_EN) or 0 (not defined); `wr_req`+`rd_req` when empty → write only, `count`=1.

Source files
------------

// File: rtl/fifo8x9_ctrl.sv
// fifo8x9_ctrl: sequencing controller for the 8-deep, 9-bit register-file FIFO datapath.
// Define FIFO8X9_CTRL_ERR_EN to build the sticky overflow/underflow flags.
module fifo8x9_ctrl #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  input  logic             rd_req,
  input  logic             flush,
  output logic             wr_ready,
  output logic             rd_ready,
  output logic             wren,
  output logic             WrInc,
  output logic             rden,
  output logic             RdInc,
  output logic             WrPtrClr,
  output logic             RdPtrClr,
  output logic             rd_valid,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             err_ovf,
  output logic             err_udf
);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_READY = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] count_q;
  logic             rd_valid_q;
  logic             in_ready;
  logic             accept_ok;
  logic             wr_acc;
  logic             rd_acc;

  // Every decoded output is held low while rst is asserted, whatever the state.
  assign in_ready  = (state == ST_READY) && !rst;
  assign accept_ok = in_ready && !flush;

  assign full  = (count_q == CNT_MAX);
  assign empty = (count_q == '0);
  assign count = count_q;

  // A write into a full FIFO is fine when a read frees the oldest slot in the same cycle.
  assign wr_acc = accept_ok && wr_req && (!full || rd_req);
  assign rd_acc = accept_ok && rd_req && !empty;

  assign wr_ready = in_ready && !full;
  assign rd_ready = in_ready && !empty;

  assign wren  = wr_acc;
  assign WrInc = wr_acc;
  assign rden  = rd_acc;
  assign RdInc = rd_acc;

  assign WrPtrClr = !rst && (state != ST_READY);
  assign RdPtrClr = !rst && (state != ST_READY);

  assign rd_valid = rd_valid_q;

  always_comb begin
    state_nxt = ST_READY;
    case (state)
      ST_INIT:  state_nxt = ST_READY;
      ST_READY: state_nxt = flush ? ST_FLUSH : ST_READY;
      ST_FLUSH: state_nxt = ST_READY;
      default:  state_nxt = ST_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Simultaneous accepted write and read leave occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (state != ST_READY) begin
      count_q <= '0;
    end else if (wr_acc && !rd_acc) begin
      count_q <= count_q + CNT_W'(1);
    end else if (rd_acc && !wr_acc) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
    end
  end

`ifdef FIFO8X9_CTRL_ERR_EN
  logic err_ovf_q;
  logic err_udf_q;

  // Flags stick until reset or an accepted flush; dropped requests never raise them.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else if (state == ST_READY && flush) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else if (state == ST_READY) begin
      if (wr_req && full && !rd_req) begin
        err_ovf_q <= 1'b1;
      end
      if (rd_req && empty) begin
        err_udf_q <= 1'b1;
      end
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
`else
  assign err_ovf = 1'b0;
  assign err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// tb_fifo8x9_ctrl: directed vector bench for fifo8x9_ctrl with a behavioural 8x9 datapath model
// so read-data order can be checked end to end.
module tb_fifo8x9_ctrl;

`ifdef FIFO8X9_CTRL_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  typedef struct {
    logic       rs;
    logic       wr;
    logic       rd;
    logic       fl;
    logic [8:0] din;
    logic       e_wren;
    logic       e_rden;
    logic       e_clr;
    logic       e_wrr;
    logic       e_rdr;
    logic [3:0] e_cnt;
    logic       e_rv;
    logic [8:0] e_dout;
    logic       e_ovf;
    logic       e_udf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req;
  logic       rd_req;
  logic       flush;
  logic [8:0] data_in;
  logic       wr_ready;
  logic       rd_ready;
  logic       wren;
  logic       WrInc;
  logic       rden;
  logic       RdInc;
  logic       WrPtrClr;
  logic       RdPtrClr;
  logic       rd_valid;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       err_ovf;
  logic       err_udf;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[$];

  // Datapath model driven by the controller strobes.
  logic [8:0] mem [8];
  logic [2:0] wp = 3'd0;
  logic [2:0] rp = 3'd0;
  logic [8:0] data_out = 9'd0;

  always #5 clk = ~clk;

  fifo8x9_ctrl #(.DEPTH(8), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_req   (wr_req),
    .rd_req   (rd_req),
    .flush    (flush),
    .wr_ready (wr_ready),
    .rd_ready (rd_ready),
    .wren     (wren),
    .WrInc    (WrInc),
    .rden     (rden),
    .RdInc    (RdInc),
    .WrPtrClr (WrPtrClr),
    .RdPtrClr (RdPtrClr),
    .rd_valid (rd_valid),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .err_ovf  (err_ovf),
    .err_udf  (err_udf)
  );

  always @(posedge clk) begin
    if (WrPtrClr) wp <= 3'd0;
    else if (WrInc) wp <= wp + 3'd1;
    if (RdPtrClr) rp <= 3'd0;
    else if (RdInc) rp <= rp + 3'd1;
    if (wren) mem[wp] <= data_in;
    if (rden) data_out <= mem[rp];
  end

  function automatic vec_t mk(input logic rs, input logic wr, input logic rd, input logic fl,
                              input logic [8:0] din, input logic e_wren, input logic e_rden,
                              input logic e_clr, input logic e_wrr, input logic e_rdr,
                              input logic [3:0] e_cnt, input logic e_rv, input logic [8:0] e_dout,
                              input logic e_ovf, input logic e_udf);
    vec_t v;
    v.rs = rs; v.wr = wr; v.rd = rd; v.fl = fl; v.din = din;
    v.e_wren = e_wren; v.e_rden = e_rden; v.e_clr = e_clr;
    v.e_wrr = e_wrr; v.e_rdr = e_rdr; v.e_cnt = e_cnt;
    v.e_rv = e_rv; v.e_dout = e_dout; v.e_ovf = e_ovf; v.e_udf = e_udf;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst     = v.rs;
    wr_req  = v.wr;
    rd_req  = v.rd;
    flush   = v.fl;
    data_in = v.din;
    #1;
  endtask

  task automatic checkVector(input vec_t v, input string tag);
    checkOutput({tag, ".wren"},     9'(wren),     9'(v.e_wren));
    checkOutput({tag, ".WrInc"},    9'(WrInc),    9'(v.e_wren));
    checkOutput({tag, ".rden"},     9'(rden),     9'(v.e_rden));
    checkOutput({tag, ".RdInc"},    9'(RdInc),    9'(v.e_rden));
    checkOutput({tag, ".WrPtrClr"}, 9'(WrPtrClr), 9'(v.e_clr));
    checkOutput({tag, ".RdPtrClr"}, 9'(RdPtrClr), 9'(v.e_clr));
    checkOutput({tag, ".wr_ready"}, 9'(wr_ready), 9'(v.e_wrr));
    checkOutput({tag, ".rd_ready"}, 9'(rd_ready), 9'(v.e_rdr));
    checkOutput({tag, ".count"},    9'(count),    9'(v.e_cnt));
    checkOutput({tag, ".full"},     9'(full),     9'(v.e_cnt == 4'd8));
    checkOutput({tag, ".empty"},    9'(empty),    9'(v.e_cnt == 4'd0));
    checkOutput({tag, ".rd_valid"}, 9'(rd_valid), 9'(v.e_rv));
    checkOutput({tag, ".err_ovf"},  9'(err_ovf),  9'(v.e_ovf & ERR_ON));
    checkOutput({tag, ".err_udf"},  9'(err_udf),  9'(v.e_udf & ERR_ON));
    if (v.e_rv) checkOutput({tag, ".data"}, data_out, v.e_dout);
  endtask

  task automatic runStep(input vec_t v, input string tag);
    applyStimulus(v);
    checkVector(v, tag);
  endtask

  initial begin
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; flush = 1'b0; data_in = 9'd0;

    // Reset, INIT, underflow attempt, fill, overflow attempt, drain.
    vecs.push_back(mk(1,1,1,0, 9'h000, 0,0,0,0,0, 4'd0, 0, 9'h000, 0,0));
    vecs.push_back(mk(0,1,0,0, 9'h0AA, 0,0,1,0,0, 4'd0, 0, 9'h000, 0,0));
    vecs.push_back(mk(0,0,1,0, 9'h000, 0,0,0,1,0, 4'd0, 0, 9'h000, 0,0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0,1,0,0, 9'(9'h101 + i), 1,0,0,1,(i > 0), 4'(i), 0, 9'h000, 0,1));
    vecs.push_back(mk(0,1,0,0, 9'h109, 0,0,0,0,1, 4'd8, 0, 9'h000, 0,1));
    vecs.push_back(mk(0,0,0,0, 9'h000, 0,0,0,0,1, 4'd8, 0, 9'h000, 1,1));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0,0,1,0, 9'h000, 0,1,0,(i > 0),1, 4'(8 - i), (i > 0),
                        9'(9'h100 + i), 1,1));
    vecs.push_back(mk(0,0,0,0, 9'h000, 0,0,0,1,0, 4'd0, 1, 9'h108, 1,1));
    vecs.push_back(mk(0,0,0,0, 9'h000, 0,0,0,1,0, 4'd0, 0, 9'h000, 1,1));

    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) runStep(vecs[i], $sformatf("tbl%0d", i));

    // Flush at count 5 with a concurrent write request.
    for (int i = 0; i < 5; i++)
      runStep(mk(0,1,0,0, 9'(9'h1A0 + i), 1,0,0,1,(i > 0), 4'(i), 0, 9'h000, 1,1),
              $sformatf("fl_wr%0d", i));
    runStep(mk(0,1,0,1, 9'h1AF, 0,0,0,1,1, 4'd5, 0, 9'h000, 1,1), "fl_req");
    runStep(mk(0,1,1,0, 9'h1EE, 0,0,1,0,0, 4'd5, 0, 9'h000, 0,0), "fl_state");
    runStep(mk(0,0,0,0, 9'h000, 0,0,0,1,0, 4'd0, 0, 9'h000, 0,0), "fl_ready");

    // Fill, then simultaneous read/write at full, then drain and check order.
    for (int i = 0; i < 8; i++)
      runStep(mk(0,1,0,0, 9'(9'h201 + i), 1,0,0,1,(i > 0), 4'(i), 0, 9'h000, 0,0),
              $sformatf("fw_wr%0d", i));
    for (int j = 0; j < 3; j++)
      runStep(mk(0,1,1,0, 9'(9'h209 + j), 1,1,0,0,1, 4'd8, (j > 0), 9'(9'h200 + j), 0,0),
              $sformatf("fw_both%0d", j));
    for (int i = 0; i < 8; i++)
      runStep(mk(0,0,1,0, 9'h000, 0,1,0,(i > 0),1, 4'(8 - i), 1, 9'(9'h203 + i), 0,0),
              $sformatf("fw_rd%0d", i));
    runStep(mk(0,0,0,0, 9'h000, 0,0,0,1,0, 4'd0, 1, 9'h20B, 0,0), "fw_last");

    // Empty with both requests: write only, no bypass.
    runStep(mk(0,1,1,0, 9'h300, 1,0,0,1,0, 4'd0, 0, 9'h000, 0,0), "em_both");
    runStep(mk(0,0,1,0, 9'h000, 0,1,0,1,1, 4'd1, 0, 9'h000, 0,1), "em_rd");
    runStep(mk(0,0,0,0, 9'h000, 0,0,0,1,0, 4'd0, 1, 9'h300, 0,1), "em_data");

    // Reset mid-operation discards the pending rd_valid and reruns INIT.
    runStep(mk(0,1,0,0, 9'h3AA, 1,0,0,1,0, 4'd0, 0, 9'h000, 0,1), "mr_wr");
    runStep(mk(0,0,1,0, 9'h000, 0,1,0,1,1, 4'd1, 0, 9'h000, 0,1), "mr_rd");
    runStep(mk(1,1,1,0, 9'h000, 0,0,0,0,0, 4'd0, 1, 9'h3AA, 0,1), "mr_rst0");
    runStep(mk(1,0,0,0, 9'h000, 0,0,0,0,0, 4'd0, 0, 9'h000, 0,0), "mr_rst1");
    runStep(mk(0,1,0,0, 9'h000, 0,0,1,0,0, 4'd0, 0, 9'h000, 0,0), "mr_init");
    runStep(mk(0,0,0,0, 9'h000, 0,0,0,1,0, 4'd0, 0, 9'h000, 0,0), "mr_ready");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
